// File: rtl/uc_control_seq.sv
// Sequenced control unit for the microc datapath: opcode decode plus RUN/PAUSE/HALT
// sequencing, single-step support, a sticky illegal-opcode flag and a saturating
// retired-instruction counter.
module uc_control_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             step_mode,
    input  logic             resume,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             halted,
    output logic             paused,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exec, skip, op_halt, op_ill;

    always_comb begin
        exec    = (state_q == RUN) || ((state_q == PAUSE) && resume);
        skip    = (state_q == HALT) && resume;
        op_halt = (Opcode == 6'b000111);
        // Everything in 001000..011111 is undefined.
        op_ill  = ~Opcode[5] & (Opcode[4] | Opcode[3]);

        s_inc     = 1'b1;
        s_inm     = 1'b0;
        we        = 1'b0;
        wez       = 1'b0;
        ALUOp     = 3'b000;
        pc_en     = 1'b0;
        state_d   = state_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        if (exec) begin
            pc_en = ~op_halt;
            if (Opcode[5]) begin
                we    = 1'b1;
                wez   = 1'b1;
                ALUOp = Opcode[4:2];
            end else if (Opcode[4:2] == 3'b000) begin
                we    = 1'b1;
                s_inm = 1'b1;
            end else if (Opcode[4:2] == 3'b001) begin
                case (Opcode[1:0])
                    2'b00:   s_inc = 1'b0;
                    2'b01:   s_inc = ~zero;
                    2'b10:   s_inc = zero;
                    default: s_inc = 1'b1;
                endcase
            end
            if (op_ill) begin
                illegal_d = 1'b1;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = op_halt ? HALT : (step_mode ? PAUSE : RUN);
        end else if (skip) begin
            // Skip cycle: advance the PC past the HALT word without counting it.
            pc_en   = 1'b1;
            state_d = step_mode ? PAUSE : RUN;
        end

        if (!reset) begin
            s_inc = 1'b1;
            s_inm = 1'b0;
            we    = 1'b0;
            wez   = 1'b0;
            ALUOp = 3'b000;
            pc_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign halted      = reset && (state_q == HALT);
    assign paused      = reset && (state_q == PAUSE);
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_control_seq.sv
// Bench for uc_control_seq: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_uc_control_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        zero, step_mode, resume;
    logic        s_inc, s_inm, we, wez, pc_en, halted, paused, illegal;
    logic [2:0]  ALUOp;
    logic [15:0] instr_count;

    logic        s_inc4, s_inm4, we4, wez4, pc_en4, halted4, paused4, illegal4;
    logic [2:0]  ALUOp4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: 0 = running, 1 = paused, 2 = halted
    int m_mode = 0;
    bit m_ill  = 1'b0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    uc_control_seq #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
        .step_mode(step_mode), .resume(resume),
        .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp),
        .pc_en(pc_en), .halted(halted), .paused(paused), .illegal(illegal),
        .instr_count(instr_count)
    );

    uc_control_seq #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
        .step_mode(step_mode), .resume(resume),
        .s_inc(s_inc4), .s_inm(s_inm4), .we(we4), .wez(wez4), .ALUOp(ALUOp4),
        .pc_en(pc_en4), .halted(halted4), .paused(paused4), .illegal(illegal4),
        .instr_count(cnt4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic z, input logic sm, input logic rs);
        @(posedge clk);
        #1;
        Opcode    = op;
        zero      = z;
        step_mode = sm;
        resume    = rs;
        #1;
    endtask

    function automatic bit op_defined(input int op);
        return (op >= 32) || (op <= 7);
    endfunction

    // Model state advance on each rising edge
    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0;
            m_ill  = 1'b0;
            m_cnt  = 0;
        end else if (m_mode == 0 || (m_mode == 1 && resume)) begin
            m_cnt++;
            if (!op_defined(int'(Opcode))) m_ill = 1'b1;
            if (Opcode == 6'd7) m_mode = 2;
            else m_mode = step_mode ? 1 : 0;
        end else if (m_mode == 2 && resume) begin
            m_mode = step_mode ? 1 : 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        int op, e_alu, e16, e4;
        bit e_inc, e_inm, e_we, e_wez, e_pc, e_h, e_p, e_ill;
        if (chk_en) begin
            op = int'(Opcode);
            e_inc = 1; e_inm = 0; e_we = 0; e_wez = 0; e_alu = 0; e_pc = 0;
            e_h = 0; e_p = 0; e_ill = 0; e16 = 0; e4 = 0;
            if (reset) begin
                e_h   = (m_mode == 2);
                e_p   = (m_mode == 1);
                e_ill = m_ill;
                e16   = (m_cnt > 65535) ? 65535 : m_cnt;
                e4    = (m_cnt > 15) ? 15 : m_cnt;
                if (m_mode == 0 || (m_mode == 1 && resume)) begin
                    e_pc = (op != 7);
                    if (op >= 32) begin
                        e_we = 1; e_wez = 1; e_alu = (op / 4) % 8;
                    end else if (op < 4) begin
                        e_we = 1; e_inm = 1;
                    end else if (op == 4) e_inc = 0;
                    else if (op == 5) e_inc = !zero;
                    else if (op == 6) e_inc = zero;
                end else if (m_mode == 2 && resume) begin
                    e_pc = 1;
                end
            end
            chk("outputs", {21'd0, s_inc, s_inm, we, wez, ALUOp, pc_en, halted, paused, illegal},
                {21'd0, e_inc, e_inm, e_we, e_wez, e_alu[2:0], e_pc, e_h, e_p, e_ill});
            chk("count16", {16'd0, instr_count}, e16);
            chk("count4", {28'd0, cnt4}, e4);
        end
    end

    initial begin
        reset = 1'b0; Opcode = 6'd0; zero = 1'b0; step_mode = 1'b0; resume = 1'b0;
        chk_en = 1'b1;
        drive(6'b101000, 0, 0, 0);
        chk("rst_we", we, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_s_inc", s_inc, 1);
        chk("rst_count", instr_count, 0);

        // ALU op right after reset release
        drive(6'b101000, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("alu_we_wez", {we, wez}, 2'b11);
        chk("alu_aluop", ALUOp, 3'b010);
        chk("alu_inc_inm_pc", {s_inc, s_inm, pc_en}, 3'b101);

        // Conditional jumps
        drive(6'b000101, 1, 0, 0);
        chk("cnt_after_first", instr_count, 1);
        chk("jz_taken", {s_inc, we}, 2'b00);
        drive(6'b000101, 0, 0, 0);
        chk("jz_not_taken", {s_inc, we}, 2'b10);
        drive(6'b000110, 1, 0, 0);
        chk("jnz_not_taken", {s_inc, we}, 2'b10);
        drive(6'b000110, 0, 0, 0);
        chk("jnz_taken", {s_inc, we}, 2'b00);

        // HALT, hold, skip
        drive(6'b000111, 0, 0, 0);
        chk("halt_decode", {pc_en, we, halted}, 3'b000);
        for (int i = 0; i < 10; i++) begin
            drive(6'b100000, 0, 0, 0);
            chk("halt_hold", {halted, pc_en, we}, 3'b100);
            chk("halt_count", instr_count, 6);
        end
        drive(6'b100000, 0, 0, 1);
        chk("skip_cycle", {pc_en, s_inc, we, wez}, 4'b1100);
        drive(6'b100000, 0, 0, 0);
        chk("after_skip", {halted, we}, 2'b01);
        chk("skip_not_counted", instr_count, 6);

        // Single step
        drive(6'b000010, 0, 1, 0);
        chk("li_step", {s_inm, we, wez, paused}, 4'b1100);
        drive(6'b100100, 0, 1, 0);
        chk("paused_idle", {paused, pc_en, we}, 3'b100);
        drive(6'b100100, 0, 1, 1);
        chk("step_exec", {we, pc_en}, 2'b11);
        drive(6'b100100, 0, 1, 0);
        chk("repaused", {paused, pc_en, we}, 3'b100);

        // Illegal opcode, sticky
        drive(6'b010000, 0, 0, 1);
        chk("nop_outputs", {we, wez, s_inc, pc_en, illegal}, 5'b00110);
        drive(6'b101000, 0, 0, 0);
        chk("illegal_set", {illegal, we}, 2'b11);
        drive(6'b000000, 0, 0, 0);
        chk("illegal_sticky", illegal, 1);

        // Saturation of the narrow counter
        for (int i = 0; i < 20; i++) drive(6'b100000 | 6'(i % 32), 0, 0, 0);
        chk("cnt4_saturated", cnt4, 4'hF);

        // Asynchronous reset mid-HALT
        drive(6'b000111, 0, 0, 0);
        drive(6'b100000, 0, 0, 0);
        chk("halted_before_rst", halted, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outs", {halted, paused, pc_en, we, s_inc}, 5'b00001);
        chk("async_rst_regs", {illegal, instr_count, cnt4}, 21'd0);
        drive(6'b100000, 0, 0, 0);
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [5:0] op;
            r = $urandom_range(0, 9);
            case (r)
                0:       op = 6'd7;
                1:       op = 6'($urandom_range(8, 31));
                2, 3:    op = 6'($urandom_range(4, 6));
                4:       op = 6'($urandom_range(0, 3));
                default: op = 6'($urandom_range(32, 63));
            endcase
            drive(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0));
            reset = ($urandom_range(0, 199) != 0);
        end
        reset = 1'b1;
        drive(6'b100000, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
